rf_wb_arbiter: RTL and testbench

- Controls the single write port of the 32-entry register file.
- Arbitrates round-robin between two writeback sources: req0 (ALU/short path) and req1 (LSU/long-latency path).
- Keeps a per-register pending scoreboard, set at issue and cleared when the write lands, so decode can detect RAW/WAW hazards.
- Sits between execute/writeback and the register file write inputs (we, rdst_id, rdst).

---
 rtl/rf_wb_arbiter_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its scoreboard.
package rf_wb_arbiter_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned REG_ID_W  = 5;
   localparam int unsigned WB_DATA_W = 32;

   typedef logic [REG_ID_W-1:0] reg_id_t;

   localparam reg_id_t REG_ZERO = 5'd0;

   typedef struct packed {
      logic                 valid;
      reg_id_t              rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      GRANT_REQ0 = 1'b0,
      GRANT_REQ1 = 1'b1
   } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set at issue, cleared when the writeback commits.
// Queries read the registered vector only; x0 is never pending.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    set_en,
   input  reg_id_t set_rd,
   input  logic    clr_en,
   input  reg_id_t clr_rd,
   input  reg_id_t q0_rd,
   input  reg_id_t q1_rd,
   input  reg_id_t q2_rd,
   output logic    q0_busy_c,
   output logic    q1_busy_c,
   output logic    q2_busy_c
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Clear first so a same-register set on the same edge wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (set_en) begin
         busy_d[set_rd] = 1'b1;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign q0_busy_c = busy_q[q0_rd];
   assign q1_busy_c = busy_q[q1_rd];
   assign q2_busy_c = busy_q[q2_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU writebacks onto the single register
// file write port, with a registered output stage and a pending-write scoreboard.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned DWIDTH = WB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic [4:0]        iss_rd,
   output logic              iss_ready,
   input  logic [4:0]        q_rs1,
   input  logic [4:0]        q_rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              req0_valid,
   input  logic [4:0]        req0_rd,
   input  logic [DWIDTH-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [4:0]        req1_rd,
   input  logic [DWIDTH-1:0] req1_data,
   output logic              req1_ready,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [DWIDTH-1:0] wb_data
);

   wb_req_t req0;
   wb_req_t req1;
   wb_req_t win;

   grant_e  last_grant_q;
   grant_e  last_grant_d;
   logic    grant0_c;
   logic    grant1_c;
   logic    xfer_c;
   logic    iss_busy_c;

   logic              wb_we_q;
   logic              wb_we_d;
   reg_id_t           wb_rd_q;
   reg_id_t           wb_rd_d;
   logic [DWIDTH-1:0] wb_data_q;
   logic [DWIDTH-1:0] wb_data_d;

   always_comb begin
      req0       = '0;
      req1       = '0;
      req0.valid = req0_valid;
      req0.rd    = req0_rd;
      req0.data  = WB_DATA_W'(req0_data);
      req1.valid = req1_valid;
      req1.rd    = req1_rd;
      req1.data  = WB_DATA_W'(req1_data);
   end

   // On a conflict the requester that did not win last time gets the slot.
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (req0.valid && req1.valid) begin
         if (last_grant_q == GRANT_REQ1) begin
            grant0_c = 1'b1;
         end else begin
            grant1_c = 1'b1;
         end
      end else begin
         grant0_c = req0.valid;
         grant1_c = req1.valid;
      end
   end

   assign req0_ready = grant0_c && !rst;
   assign req1_ready = grant1_c && !rst;

   always_comb begin
      last_grant_d = last_grant_q;
      wb_we_d      = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      win          = grant1_c ? req1 : req0;
      xfer_c       = (grant0_c || grant1_c) && win.valid;
      // An x0 winner still consumes its slot and loads the stage, but never writes.
      if (xfer_c) begin
         last_grant_d = grant1_c ? GRANT_REQ1 : GRANT_REQ0;
         wb_we_d      = (win.rd != REG_ZERO);
         wb_rd_d      = win.rd;
         wb_data_d    = DWIDTH'(win.data);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_REQ1;
         wb_we_q      <= 1'b0;
         wb_rd_q      <= REG_ZERO;
         wb_data_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wb_we_q      <= wb_we_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign wb_we   = wb_we_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;

   // The clear lands on the same edge the register file commits the write.
   rf_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (iss_valid && iss_ready),
      .set_rd    (iss_rd),
      .clr_en    (wb_we_q),
      .clr_rd    (wb_rd_q),
      .q0_rd     (iss_rd),
      .q1_rd     (q_rs1),
      .q2_rd     (q_rs2),
      .q0_busy_c (iss_busy_c),
      .q1_busy_c (rs1_busy),
      .q2_busy_c (rs2_busy)
   );

   assign iss_ready = !iss_busy_c;

   // A requester left waiting must present the same request on the next cycle.
   a_req0_hold : assert property (@(posedge clk) disable iff (rst)
      (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_rd) && $stable(req0_data)));
   a_req1_hold : assert property (@(posedge clk) disable iff (rst)
      (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_rd) && $stable(req1_data)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table followed by constrained-random
// traffic checked against a cycle-level reference model.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        req0_valid;
   logic [4:0]  req0_rd;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_rd;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DWIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .iss_ready  (iss_ready),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .req0_valid (req0_valid),
      .req0_rd    (req0_rd),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rd    (req1_rd),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic        v0;
      logic [4:0]  rd0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  rd1;
      logic [31:0] d1;
      logic        r0;
      logic        r1;
      logic        ir;
      logic        b1;
      logic        b2;
      logic        we;
      logic [4:0]  wrd;
      logic [31:0] wdata;
   } vec_t;

   function automatic vec_t mk(int r, int iv, int ird, int q1, int q2,
                               int v0, int rd0, int d0, int v1, int rd1, int d1,
                               int r0, int r1, int ir, int b1, int b2,
                               int we, int wrd, int wdata);
      vec_t v;
      v.rst = 1'(r);   v.iv = 1'(iv);   v.ird = 5'(ird); v.q1 = 5'(q1); v.q2 = 5'(q2);
      v.v0  = 1'(v0);  v.rd0 = 5'(rd0); v.d0 = 32'(d0);
      v.v1  = 1'(v1);  v.rd1 = 5'(rd1); v.d1 = 32'(d1);
      v.r0  = 1'(r0);  v.r1 = 1'(r1);   v.ir = 1'(ir);   v.b1 = 1'(b1); v.b2 = 1'(b2);
      v.we  = 1'(we);  v.wrd = 5'(wrd); v.wdata = 32'(wdata);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      rst        = v.rst;
      iss_valid  = v.iv;
      iss_rd     = v.ird;
      q_rs1      = v.q1;
      q_rs2      = v.q2;
      req0_valid = v.v0;
      req0_rd    = v.rd0;
      req0_data  = v.d0;
      req1_valid = v.v1;
      req1_rd    = v.rd1;
      req1_data  = v.d1;
   endtask

   task automatic check_all(input string tag, input vec_t e);
      chk({tag, " req0_ready"}, 32'(req0_ready), 32'(e.r0));
      chk({tag, " req1_ready"}, 32'(req1_ready), 32'(e.r1));
      chk({tag, " iss_ready"},  32'(iss_ready),  32'(e.ir));
      chk({tag, " rs1_busy"},   32'(rs1_busy),   32'(e.b1));
      chk({tag, " rs2_busy"},   32'(rs2_busy),   32'(e.b2));
      chk({tag, " wb_we"},      32'(wb_we),      32'(e.we));
      chk({tag, " wb_rd"},      32'(wb_rd),      32'(e.wrd));
      chk({tag, " wb_data"},    wb_data,         e.wdata);
   endtask

   // Reference model state: pending flags per register, last winner, output stage.
   bit          m_busy[32];
   int          m_last;
   bit          m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   function automatic void model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last = 1;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
   endfunction

   function automatic int model_winner(input bit v0, input bit v1);
      if (v0 && v1) return 1 - m_last;
      if (v0)       return 0;
      if (v1)       return 1;
      return -1;
   endfunction

   // Advance the model across one clock edge with the inputs of vector v.
   function automatic void model_step(input vec_t v);
      int  w;
      bit  issue_ok;
      if (v.rst) begin
         model_reset();
         return;
      end
      w        = model_winner(v.v0, v.v1);
      issue_ok = v.iv && (v.ird != 0) && !m_busy[v.ird];
      if (m_we) m_busy[m_rd] = 1'b0;
      if (issue_ok) m_busy[v.ird] = 1'b1;
      if (w < 0) begin
         m_we = 1'b0;
      end else begin
         m_last = w;
         m_rd   = (w == 0) ? v.rd0 : v.rd1;
         m_data = (w == 0) ? v.d0 : v.d1;
         m_we   = (m_rd != 0);
      end
   endfunction

   function automatic vec_t model_expect(input vec_t v);
      vec_t e = v;
      int   w = model_winner(v.v0, v.v1);
      e.r0    = (w == 0) && !v.rst;
      e.r1    = (w == 1) && !v.rst;
      e.ir    = (v.ird == 0) || !m_busy[v.ird];
      e.b1    = (v.q1 != 0) && m_busy[v.q1];
      e.b2    = (v.q2 != 0) && m_busy[v.q2];
      e.we    = m_we;
      e.wrd   = m_rd;
      e.wdata = m_data;
      return e;
   endfunction

   vec_t tbl[$];

   initial begin
      vec_t v;
      vec_t e;
      bit   hold0;
      bit   hold1;
      int   w;

      //            rst iv ird q1 q2  v0 rd0 d0      v1 rd1 d1      r0 r1 ir b1 b2 we wrd wdata
      tbl.push_back(mk(0, 0, 7,  3, 31, 0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0,  1, 5, 'h1234, 0, 0, 0,       1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 1, 5, 'h1234));
      tbl.push_back(mk(0, 0, 0,  0, 0,  1, 1, 'h11,   1, 2, 'h22,    0, 1, 1, 0, 0, 0, 5, 'h1234));
      tbl.push_back(mk(0, 0, 0,  0, 0,  1, 1, 'h11,   1, 2, 'h23,    1, 0, 1, 0, 0, 1, 2, 'h22));
      tbl.push_back(mk(0, 0, 0,  0, 0,  1, 1, 'h12,   1, 2, 'h23,    0, 1, 1, 0, 0, 1, 1, 'h11));
      tbl.push_back(mk(0, 0, 0,  0, 0,  1, 1, 'h12,   1, 2, 'h24,    1, 0, 1, 0, 0, 1, 2, 'h23));
      tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,      1, 2, 'h24,    0, 1, 1, 0, 0, 1, 1, 'h12));
      tbl.push_back(mk(0, 1, 7,  7, 0,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 1, 2, 'h24));
      tbl.push_back(mk(0, 0, 7,  7, 7,  0, 0, 0,      0, 0, 0,       0, 0, 0, 1, 1, 0, 2, 'h24));
      tbl.push_back(mk(0, 0, 7,  7, 0,  0, 0, 0,      1, 7, 'h77,    0, 1, 0, 1, 0, 0, 2, 'h24));
      tbl.push_back(mk(0, 0, 7,  7, 0,  0, 0, 0,      0, 0, 0,       0, 0, 0, 1, 0, 1, 7, 'h77));
      tbl.push_back(mk(0, 0, 7,  7, 0,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 0, 7, 'h77));
      tbl.push_back(mk(0, 0, 9,  0, 0,  1, 9, 'h99,   0, 0, 0,       1, 0, 1, 0, 0, 0, 7, 'h77));
      tbl.push_back(mk(0, 1, 9,  9, 0,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 1, 9, 'h99));
      tbl.push_back(mk(0, 0, 9,  9, 0,  0, 0, 0,      0, 0, 0,       0, 0, 0, 1, 0, 0, 9, 'h99));
      tbl.push_back(mk(0, 0, 0,  0, 9,  1, 0, 'h55,   0, 0, 0,       1, 0, 1, 0, 1, 0, 9, 'h99));
      tbl.push_back(mk(0, 1, 0,  0, 9,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 'h55));
      tbl.push_back(mk(0, 0, 0,  0, 9,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 'h55));
      tbl.push_back(mk(0, 1, 3,  3, 9,  1, 6, 'h66,   1, 4, 'h44,    0, 1, 1, 0, 1, 0, 0, 'h55));
      tbl.push_back(mk(1, 0, 3,  3, 9,  1, 6, 'h66,   1, 8, 'h88,    0, 0, 0, 1, 1, 1, 4, 'h44));
      tbl.push_back(mk(0, 0, 3,  3, 9,  1, 6, 'h66,   1, 8, 'h88,    1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  4, 9,  0, 0, 0,      1, 8, 'h88,    0, 1, 1, 0, 0, 1, 6, 'h66));
      tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0, 1, 8, 'h88));

      // Reset, then idle: every register reads free and no write is issued.
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset wb_we", 32'(wb_we), 32'd0);
      chk("reset wb_rd", 32'(wb_rd), 32'd0);
      chk("reset wb_data", wb_data, 32'd0);
      for (int i = 0; i < 32; i++) begin
         q_rs1  = 5'(i);
         q_rs2  = 5'(31 - i);
         iss_rd = 5'(i);
         #1;
         chk($sformatf("idle rs1_busy[%0d]", i), 32'(rs1_busy), 32'd0);
         chk($sformatf("idle rs2_busy[%0d]", 31 - i), 32'(rs2_busy), 32'd0);
         chk($sformatf("idle iss_ready[%0d]", i), 32'(iss_ready), 32'd1);
      end

      // Directed table: one row per cycle, expectations derived by hand.
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         check_all($sformatf("row%0d", i), tbl[i]);
      end

      // Randomized traffic against the reference model, after a fresh reset.
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      model_reset();
      hold0 = 1'b0;
      hold1 = 1'b0;
      v     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
         v.rst = ($urandom_range(0, 59) == 0);
         v.iv  = $urandom_range(0, 1) != 0;
         v.ird = 5'($urandom_range(0, 7));
         v.q1  = 5'($urandom_range(0, 7));
         v.q2  = 5'($urandom_range(0, 31));
         if (!hold0) begin
            v.v0  = $urandom_range(0, 2) != 0;
            v.rd0 = 5'($urandom_range(0, 7));
            v.d0  = $urandom;
         end
         if (!hold1) begin
            v.v1  = $urandom_range(0, 2) != 0;
            v.rd1 = 5'($urandom_range(0, 7));
            v.d1  = $urandom;
         end
         drive(v);
         #1;
         e = model_expect(v);
         check_all($sformatf("rand%0d", c), e);
         w     = model_winner(v.v0, v.v1);
         hold0 = v.v0 && (w != 0) && !v.rst;
         hold1 = v.v1 && (w != 1) && !v.rst;
         model_step(v);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
